adder_cla_pipe: RTL and testbench
=================================

Name: adder_cla_pipe

Overview:
- Parametrised, pipelined successor to the 32-bit two-level CLA adder.
- The adder is split into segments of SEG bits, and each segment uses a 4-bit-group CLA internally. One segment resolves per clock; the carry is registered between segments.
- Adds add/subtract mode, carry-in, carry-out, signed overflow, and a valid/ready handshake with backpressure.
- Sits between operand-issue logic and result consumers in the datapath.

Parameters:
- WIDTH, 32: operand and result width. Must be a multiple of SEG.
- SEG, 8: bits resolved per pipeline stage. Must be a multiple of 4, with 4 <= SEG <= WIDTH.
- STAGES (derived, not overridable): WIDTH/SEG, which is both the pipeline depth and the latency in cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- A  in  WIDTH  operand A (unsigned or two's complement).
- B  in  WIDTH  operand B.
- cin  in  1  carry-in. Used only when sub=0.
- sub  in  1  0 = A+B+cin; 1 = A-B, computed as A+~B+1 with cin ignored.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- S  out  WIDTH  sum/difference, modulo 2^WIDTH.
- C_out  out  1  carry out of the MSB. In sub mode, 1 means no borrow (A>=B unsigned).
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset:
  - While rst_n=0 at a rising edge, all stage valid bits clear.
  - S=0, C_out=0, ovf=0, out_valid=0.
  - in_ready is combinational: reads 1 whenever out_valid=0, including during reset.
  - In-flight beats are discarded on reset with no partial output. Reset has priority over every other event.
- Handshake:
  - Global stall signal: adv = !out_valid | out_ready. in_ready = adv.
  - A beat is accepted when in_valid & in_ready.
  - A result is consumed when out_valid & out_ready.
  - On adv=1, every stage loads from its predecessor, and stage 0 loads the new beat (or a bubble if in_valid=0).
  - On adv=0, all pipeline registers hold, and S/C_out/ovf stay stable while out_valid=1.
- Latency and throughput:
  - A beat accepted at edge t appears with out_valid=1 after edge t+STAGES-1, assuming no stall.
  - With SEG=WIDTH, the block is single-stage: a result is registered one edge after acceptance.
  - Throughput is one beat per cycle when out_ready is held high. Bubbles propagate as valid=0 and never update the output.
- Arithmetic:
  - Operand prep at stage 0: Bx = sub ? ~B : B, c0 = sub ? 1 : cin.
  - Stage k computes bits [k*SEG +: SEG] from the registered A/Bx slices and the registered carry from stage k-1 (c0 for k=0).
  - Within a segment, each 4-bit group uses CLA generate/propagate: p=a^b, g=a&b, group Pm/Gm. Inter-group carries within the segment are resolved by lookahead; no ripple across groups.
  - Upper operand slices not yet consumed are carried forward in stage registers. Completed lower sum slices are carried forward to the output.
  - The final stage also registers the carry into the MSB, used to produce ovf.
- Boundary cases:
  - All-ones plus 1 wraps to S=0, C_out=1.
  - Simultaneous accept and consume in the same cycle is legal and loses no beat.
  - in_valid may drop mid-stream; the resulting gaps appear as bubbles.
  - Holding out_ready=0 with a full pipeline does not reorder or duplicate beats.
  - Inputs are sampled only on accept.

Test Plan (WIDTH=32, SEG=8, STAGES=4):
- Reset, then one beat A=0x0000_0001, B=0x0000_0002, cin=0, sub=0 -> out_valid=1 exactly 3 cycles after the accept edge, with S=0x0000_0003, C_out=0, ovf=0.
- Full carry chain: A=0xFFFF_FFFF, B=0x0000_0000, cin=1 -> S=0x0000_0000, C_out=1, ovf=0. A=0x7FFF_FFFF, B=1, cin=0 -> S=0x8000_0000, C_out=0, ovf=1.
- Subtract: A=5, B=7, sub=1 -> S=0xFFFF_FFFE, C_out=0, ovf=0. A=0x8000_0000, B=1, sub=1 -> S=0x7FFF_FFFF, C_out=1, ovf=1. Drive cin=1 on the sub beats to confirm it is ignored.
- Backpressure: stream 8 beats back-to-back (A=i, B=i for i=0..7) and hold out_ready=0 for cycles 5-9 -> in_ready=0 during the stall, results S=0,2,4,...,14 in order with none lost or duplicated, and outputs stable while stalled.
- Mid-flight reset: accept 3 beats, assert rst_n=0 for one edge -> out_valid=0, S=0, C_out=0, ovf=0. No stale results appear afterwards, and the next beat 10+20 returns S=30 after the nominal latency.
- Random: 10k random A/B/cin/sub beats with random in_valid/out_ready, checked against a reference model; repeat with SEG=4 and SEG=32.

Source files
------------

// File: rtl/adder_cla_pipe_if.sv
// ---------------------------------------------------------------------------
// adder_cla_pipe_if
//   Operand/result bundle for the pipelined CLA adder.
//
//   Signals (direction as seen by the adder):
//     in_valid  in   operand beat valid
//     in_ready  out  adder accepts a beat this cycle
//     A, B      in   operands, WIDTH bits
//     cin       in   carry-in (ignored when sub=1)
//     sub       in   0 = A+B+cin, 1 = A-B
//     out_valid out  result valid
//     out_ready in   consumer accepts the result
//     S         out  sum/difference, WIDTH bits
//     C_out     out  carry out of the MSB (no-borrow flag when sub=1)
//     ovf       out  signed overflow
//
//   master: operand-issue side; slave: the adder itself.
// ---------------------------------------------------------------------------
interface adder_cla_pipe_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             C_out;
  logic             ovf;

  modport master (
    output in_valid, A, B, cin, sub, out_ready,
    input  in_ready, out_valid, S, C_out, ovf
  );

  modport slave (
    input  in_valid, A, B, cin, sub, out_ready,
    output in_ready, out_valid, S, C_out, ovf
  );

endinterface : adder_cla_pipe_if

// File: rtl/adder_cla_pipe.sv
// ---------------------------------------------------------------------------
// adder_cla_pipe
//   Pipelined carry-lookahead adder/subtractor. The WIDTH-bit operation is
//   split into STAGES = WIDTH/SEG segments; one segment is resolved per
//   clock, with the segment carry registered between stages. Inside a
//   segment, 4-bit groups use CLA generate/propagate and the group carries
//   are resolved by a second lookahead level (no ripple across groups).
//
//   Segment 0 is computed straight from the accepted operands, so a beat
//   accepted at edge t is visible on the outputs after edge t+STAGES-1.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    adder_cla_pipe_if.slave (operand / result handshake)
//
//   Flow control is a single global enable: adv = !out_valid | out_ready.
//   When adv is low the whole pipeline, including the result, holds.
// ---------------------------------------------------------------------------
module adder_cla_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  adder_cla_pipe_if.slave       bus
);

  localparam int STAGES = WIDTH / SEG;
  localparam int NG     = SEG / 4;      // 4-bit CLA groups per segment
  localparam int LAST   = STAGES - 1;

  if ((SEG < 4) || (SEG > WIDTH) || (SEG % 4 != 0) || (WIDTH % SEG != 0))
  begin : g_bad_params
    $error("adder_cla_pipe: SEG must be a multiple of 4 dividing WIDTH");
  end

  // Result of resolving one segment.
  typedef struct packed {
    logic [SEG-1:0] s;     // segment sum
    logic           co;    // carry out of the segment
    logic           cm;    // carry into the segment's top bit
  } seg_res_t;

  // Contents of one pipeline stage. Operand slices below the current
  // segment are dead but kept full-width for a uniform stage layout; sum
  // slices above the current segment are not yet meaningful.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] bx;  // B, already inverted in subtract mode
    logic [WIDTH-1:0] s;
    logic             c;   // carry out of the last resolved segment
    logic             cm;  // carry into the MSB of the last resolved segment
  } stage_t;

  // -------------------------------------------------------------------------
  // 4-bit lookahead: carries c[0..4] of a group from bit g/p and carry-in.
  // Written as flat sum-of-products so every carry is two logic levels.
  // -------------------------------------------------------------------------
  function automatic logic [4:0] carries4(input logic [3:0] g,
                                          input logic [3:0] p,
                                          input logic       ci);
    logic [4:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (&p & ci);
    return c;
  endfunction

  // -------------------------------------------------------------------------
  // One segment: group Pm/Gm, lookahead across groups, then per-group sums.
  // -------------------------------------------------------------------------
  function automatic seg_res_t cla_seg(input logic [SEG-1:0] a,
                                       input logic [SEG-1:0] b,
                                       input logic           ci);
    seg_res_t      r;
    logic [SEG-1:0] p;
    logic [SEG-1:0] g;
    logic [NG-1:0]  pg;
    logic [NG-1:0]  gg;
    logic [NG:0]    cg;
    logic [4:0]     c4;
    logic           term;
    logic           acc;

    p = a ^ b;
    g = a & b;

    for (int j = 0; j < NG; j++) begin
      pg[j] = &p[4*j +: 4];
      c4    = carries4(g[4*j +: 4], p[4*j +: 4], 1'b0);
      gg[j] = c4[4];
    end

    // Carry into group j as an explicit OR of product terms:
    //   cg[j] = ci&P[j-1..0] | G[0]&P[j-1..1] | ... | G[j-1]
    cg[0] = ci;
    for (int j = 1; j <= NG; j++) begin
      term = ci;
      for (int n = 0; n < j; n++) term = term & pg[n];
      acc = term;
      for (int m = 0; m < j; m++) begin
        term = gg[m];
        for (int n = m + 1; n < j; n++) term = term & pg[n];
        acc = acc | term;
      end
      cg[j] = acc;
    end

    r = '0;
    for (int j = 0; j < NG; j++) begin
      c4 = carries4(g[4*j +: 4], p[4*j +: 4], cg[j]);
      r.s[4*j +: 4] = p[4*j +: 4] ^ c4[3:0];
      if (j == NG - 1) r.cm = c4[3];
    end
    r.co = cg[NG];
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Pipeline state
  // -------------------------------------------------------------------------
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  stage_t            stg_q [STAGES];
  stage_t            stg_d [STAGES];
  logic              adv;

  assign adv          = !vld_q[LAST] | bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    logic [WIDTH-1:0] bx0;
    logic             c0;
    seg_res_t         r;

    // Operand prep: subtraction is A + ~B + 1, cin ignored.
    bx0 = bus.sub ? ~bus.B : bus.B;
    c0  = bus.sub ? 1'b1 : bus.cin;

    vld_d[0]    = bus.in_valid;
    stg_d[0]    = '0;
    stg_d[0].a  = bus.A;
    stg_d[0].bx = bx0;
    r           = cla_seg(bus.A[SEG-1:0], bx0[SEG-1:0], c0);
    stg_d[0].s[SEG-1:0] = r.s;
    stg_d[0].c  = r.co;
    stg_d[0].cm = r.cm;

    for (int k = 1; k < STAGES; k++) begin
      vld_d[k] = vld_q[k-1];
      stg_d[k] = stg_q[k-1];
      r = cla_seg(stg_q[k-1].a[k*SEG +: SEG], stg_q[k-1].bx[k*SEG +: SEG],
                  stg_q[k-1].c);
      stg_d[k].s[k*SEG +: SEG] = r.s;
      stg_d[k].c  = r.co;
      stg_d[k].cm = r.cm;
    end
  end

  // NOTE: only the valid bits and the result stage are reset; intermediate
  // datapath registers need no reset because a cleared valid bit makes
  // their contents irrelevant, and leaving them un-reset keeps the reset
  // net off the wide operand flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q       <= '0;
      stg_q[LAST] <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
      // Stages only capture real beats, so a bubble never overwrites the
      // held result.
      for (int k = 0; k < STAGES; k++) begin
        if (vld_d[k]) stg_q[k] <= stg_d[k];
      end
    end
  end

  assign bus.out_valid = vld_q[LAST];
  assign bus.S         = stg_q[LAST].s;
  assign bus.C_out     = stg_q[LAST].c;
  // Signed overflow: carry into the MSB differs from carry out of it.
  assign bus.ovf       = stg_q[LAST].c ^ stg_q[LAST].cm;

endmodule : adder_cla_pipe

// File: tb/tb_adder_cla_pipe.sv
// ---------------------------------------------------------------------------
// tb_adder_cla_pipe
//   Three adders (SEG = 8, 4, 32 at WIDTH = 32) share clock and reset.
//   Directed scenarios run on the SEG=8 instance; all three then take a
//   randomized stream with random backpressure, checked against a plain
//   arithmetic reference model and an in-order expected-result queue.
// ---------------------------------------------------------------------------
module tb_adder_cla_pipe;

  localparam int W      = 32;
  localparam int NRAND  = 10000;
  localparam int LAT8   = (W / 8) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Per-instance stimulus / observation, index 0: SEG=8, 1: SEG=4, 2: SEG=32
  logic [2:0]   iv, ir, ov, ordy, icin, isub, co, of;
  logic [W-1:0] ia [3];
  logic [W-1:0] ib [3];
  logic [W-1:0] so [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int SEGV = (g == 0) ? 8 : (g == 1) ? 4 : 32;
    adder_cla_pipe_if #(.WIDTH(W)) bus ();
    assign bus.in_valid  = iv[g];
    assign bus.A         = ia[g];
    assign bus.B         = ib[g];
    assign bus.cin       = icin[g];
    assign bus.sub       = isub[g];
    assign bus.out_ready = ordy[g];
    assign ir[g]         = bus.in_ready;
    assign ov[g]         = bus.out_valid;
    assign so[g]         = bus.S;
    assign co[g]         = bus.C_out;
    assign of[g]         = bus.ovf;
    adder_cla_pipe #(.WIDTH(W), .SEG(SEGV)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, C_out, S} from plain wide arithmetic and the sign rule
  // "same-signed addends giving a differently-signed result".
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic cin, input logic sub);
    logic [W:0]   sum;
    logic [W-1:0] bx;
    logic         o;
    bx  = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    o   = (a[W-1] == bx[W-1]) && (sum[W-1] != a[W-1]);
    return {o, sum[W], sum[W-1:0]};
  endfunction

  // Single beat on the SEG=8 instance, checking latency and result.
  task automatic run_beat(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic [W-1:0] exp_s,
                          input logic exp_c, input logic exp_o);
    int lat;
    @(negedge clk);
    iv[0] = 1'b1; ia[0] = a; ib[0] = b; icin[0] = cin; isub[0] = sub;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!ov[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(LAT8));
    check({tag, "_S"},   64'(so[0]), 64'(exp_s));
    check({tag, "_C"},   64'(co[0]), 64'(exp_c));
    check({tag, "_ovf"}, 64'(of[0]), 64'(exp_o));
  endtask

  // Randomized stream with random in_valid/out_ready on instance idx.
  task automatic run_random(input int idx, input string tag);
    logic [W+1:0] q[$];
    logic [W-1:0] a, b;
    logic         v, c, s, r;
    int           drain;
    for (int n = 0; n < NRAND + 200; n++) begin
      if (n >= NRAND && q.size() == 0) break;
      @(negedge clk);
      if (n < NRAND) begin
        v = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 9) < 7);
        case ($urandom_range(0, 7))
          0:       a = '1;
          1:       a = 32'h7FFF_FFFF;
          2:       a = 32'h8000_0000;
          default: a = $urandom;
        endcase
        case ($urandom_range(0, 7))
          0:       b = '0;
          1:       b = 32'h0000_0001;
          2:       b = '1;
          default: b = $urandom;
        endcase
        c = 1'($urandom);
        s = 1'($urandom);
      end else begin
        v = 1'b0; r = 1'b1; a = '0; b = '0; c = 1'b0; s = 1'b0;
      end
      iv[idx] = v; ia[idx] = a; ib[idx] = b; icin[idx] = c; isub[idx] = s;
      ordy[idx] = r;
      #1;
      check({tag, "_in_ready"}, 64'(ir[idx]), 64'(!ov[idx] || r));
      if (ov[idx]) begin
        if (q.size() == 0) begin
          check({tag, "_spurious_valid"}, 64'(ov[idx]), 64'(0));
        end else begin
          check({tag, "_result"}, 64'({of[idx], co[idx], so[idx]}),
                64'(q[0]));
          if (r) void'(q.pop_front());
        end
      end
      if (v && ir[idx]) q.push_back(ref_add(a, b, c, s));
    end
    drain = q.size();
    check({tag, "_drained"}, 64'(drain), 64'(0));
    iv[idx] = 1'b0;
  endtask

  initial begin
    int sent, got, stale;
    logic held_v;
    logic [W-1:0] held_s;

    rst_n = 1'b0;
    iv = '0; ordy = '0; icin = '0; isub = '0;
    for (int i = 0; i < 3; i++) begin ia[i] = '0; ib[i] = '0; end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(ov[0]), 64'(0));
    check("rst_S",         64'(so[0]), 64'(0));
    check("rst_C",         64'(co[0]), 64'(0));
    check("rst_ovf",       64'(of[0]), 64'(0));
    check("rst_in_ready",  64'(ir[0]), 64'(1));
    @(negedge clk) rst_n = 1'b1;

    // Basic, carry chain, overflow, subtract (cin=1 must be ignored)
    run_beat("add_1_2",    32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0,
             32'h0000_0003, 1'b0, 1'b0);
    run_beat("ones_cin",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0,
             32'h0000_0000, 1'b1, 1'b0);
    run_beat("maxpos_p1",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
             32'h8000_0000, 1'b0, 1'b1);
    run_beat("sub_5_7",    32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1,
             32'hFFFF_FFFE, 1'b0, 1'b0);
    run_beat("sub_min_1",  32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1,
             32'h7FFF_FFFF, 1'b1, 1'b1);

    // Backpressure: 8 back-to-back beats, out_ready low for cycles 5..9
    sent = 0; got = 0; held_v = 1'b0; held_s = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      iv[0] = (sent < 8); ia[0] = W'(sent); ib[0] = W'(sent);
      icin[0] = 1'b0; isub[0] = 1'b0;
      ordy[0] = !(cyc >= 5 && cyc <= 9);
      #1;
      if (!ordy[0] && ov[0]) check("bp_in_ready", 64'(ir[0]), 64'(0));
      if (held_v) check("bp_stable", 64'(so[0]), 64'(held_s));
      held_v = ov[0] && !ordy[0];
      held_s = so[0];
      if (ov[0] && ordy[0]) begin
        check("bp_order", 64'(so[0]), 64'(2 * got));
        got++;
      end
      if (iv[0] && ir[0]) sent++;
    end
    check("bp_count", 64'(got), 64'(8));
    @(negedge clk);
    iv[0] = 1'b0;
    #1 check("bp_no_dup", 64'(ov[0]), 64'(0));

    // Mid-flight reset
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iv[0] = 1'b1; ia[0] = W'(100 + i); ib[0] = W'(i); ordy[0] = 1'b1;
    end
    @(negedge clk);
    iv[0] = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_out_valid", 64'(ov[0]), 64'(0));
    check("mrst_S",         64'(so[0]), 64'(0));
    check("mrst_C",         64'(co[0]), 64'(0));
    check("mrst_ovf",       64'(of[0]), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      #1 if (ov[0]) stale++;
    end
    check("mrst_no_stale", 64'(stale), 64'(0));
    run_beat("post_rst", 32'd10, 32'd20, 1'b0, 1'b0, 32'd30, 1'b0, 1'b0);

    // Random streams on all three segmentations at once
    fork
      run_random(0, "rnd_seg8");
      run_random(1, "rnd_seg4");
      run_random(2, "rnd_seg32");
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_adder_cla_pipe
